id_stage_scoreboard: RTL

Parametrised decode/issue stage for the ARM-subset pipeline. It decodes the 32-bit instruction from IF, reads operands from an internal register file, and evaluates the condition code against the status register. It replaces the external hazard input with an internal scoreboard of pending register and flag writes. Decoded instructions are held in a registered ID/EXE slot with a valid/ready handshake and flush support.

---
 rtl/id_stage_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_scoreboard.sv
// id_stage_scoreboard
// Decode/issue stage for the ARM-subset pipeline. It decodes the IF
// instruction, reads operands from an internal 16-entry register file and
// evaluates the condition field against the status flags. An internal
// scoreboard counts pending register and flag writes and stalls issue on
// hazards. Issued instructions sit in a registered ID/EXE slot with a
// valid/ready handshake and flush support.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   if_instr/if_pc/if_valid     instruction, PC and valid from IF
//   if_ready                    ID accepts the IF instruction this cycle
//   ex_ready / ex_valid         EXE accepts / ID/EXE slot occupied
//   ex_*                        decoded controls, operands and fields
//   wb_en/wb_dest/wb_value      register write-back
//   sr, sr_update               current NZCV; an in-flight S op wrote sr
//   flush                       taken branch in EXE, squashes the slot
module id_stage_scoreboard #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter bit          BYPASS_WB    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic              ex_imm,
  output logic [3:0]        ex_exe_cmd,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic [3:0]        ex_dest,
  output logic [DATA_W-1:0] ex_pc,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [3:0]        sr,
  input  logic              sr_update,
  input  logic              flush
);

  localparam int unsigned   CW       = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_INFLIGHT);

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  // Instruction fields
  logic [3:0] cond, opcode, rn, rd, rm;
  logic [1:0] mode;
  logic       imm_bit, s_bit;

  assign cond    = if_instr[31:28];
  assign mode    = if_instr[27:26];
  assign imm_bit = if_instr[25];
  assign opcode  = if_instr[24:21];
  assign s_bit   = if_instr[20];
  assign rn      = if_instr[19:16];
  assign rd      = if_instr[15:12];
  // STR carries its store data register in the Rd position
  assign rm      = (mode == 2'b01) ? if_instr[15:12] : if_instr[3:0];

  // Control decode
  logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;
  logic [3:0] dec_cmd;

  always_comb begin
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_cmd = '0;
    case (mode)
      2'b00: begin
        dec_s = s_bit;
        case (opcode)
          OP_MOV: begin dec_cmd = 4'b0001; dec_wb = 1'b1; end
          OP_MVN: begin dec_cmd = 4'b1001; dec_wb = 1'b1; end
          OP_ADD: begin dec_cmd = 4'b0010; dec_wb = 1'b1; end
          OP_ADC: begin dec_cmd = 4'b0011; dec_wb = 1'b1; end
          OP_SUB: begin dec_cmd = 4'b0100; dec_wb = 1'b1; end
          OP_SBC: begin dec_cmd = 4'b0101; dec_wb = 1'b1; end
          OP_AND: begin dec_cmd = 4'b0110; dec_wb = 1'b1; end
          OP_ORR: begin dec_cmd = 4'b0111; dec_wb = 1'b1; end
          OP_EOR: begin dec_cmd = 4'b1000; dec_wb = 1'b1; end
          OP_CMP: dec_cmd = 4'b0100;
          OP_TST: dec_cmd = 4'b0110;
          default: ;
        endcase
      end
      2'b01: begin
        // Address is always base + offset; S selects LDR (1) or STR (0)
        dec_cmd = 4'b0010;
        if (s_bit) begin
          dec_mr = 1'b1;
          dec_wb = 1'b1;
        end else begin
          dec_mw = 1'b1;
        end
      end
      2'b10:   dec_b = 1'b1;
      default: ;
    endcase
  end

  // Condition check against NZCV
  logic flag_n, flag_z, flag_c, flag_v, cond_ok;

  assign {flag_n, flag_z, flag_c, flag_v} = sr;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = !flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = !flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = !flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = !flag_v;
      4'b1000: cond_ok = flag_c && !flag_z;
      4'b1001: cond_ok = !flag_c || flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ok = flag_z || (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Register file with optional same-cycle write-back forwarding
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] val_rn, val_rm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < 16; r++) rf[r] <= '0;
    end else if (wb_en) begin
      rf[wb_dest] <= wb_value;
    end
  end

  always_comb begin
    val_rn = rf[rn];
    val_rm = rf[rm];
    if (BYPASS_WB && wb_en && (wb_dest == rn)) val_rn = wb_value;
    if (BYPASS_WB && wb_en && (wb_dest == rm)) val_rm = wb_value;
  end

  // Scoreboard
  logic [CW-1:0] pend     [16];
  logic [CW-1:0] pend_nxt [16];
  logic [CW-1:0] fpend, fpend_nxt;
  logic          underflow;

  // A counter still blocks readers unless this cycle's write retires its
  // last outstanding write (only when write-back is forwarded).
  function automatic logic busy(input logic [CW-1:0] cnt, input logic hit);
    if (BYPASS_WB) return cnt > CW'(hit);
    else           return cnt != '0;
  endfunction

  function automatic logic [CW:0] cnt_up(input logic [CW-1:0] cnt, input logic inc);
    return {1'b0, cnt} + {{CW{1'b0}}, inc};
  endfunction

  function automatic logic [CW:0] cnt_down(input logic d1, input logic d2);
    return {{CW{1'b0}}, d1} + {{CW{1'b0}}, d2};
  endfunction

  // Issue, write-back and squash can all hit one counter on the same edge;
  // they are summed and the result saturates at zero.
  function automatic logic [CW-1:0] cnt_next(input logic [CW:0] up, input logic [CW:0] down);
    logic [CW:0] diff;
    diff = up - down;
    return (up < down) ? '0 : diff[CW-1:0];
  endfunction

  logic use_src1, use_src2, stall, accept, issue, squash;

  assign use_src1 = (opcode != OP_MOV) && (opcode != OP_MVN) && (mode != 2'b10);
  assign use_src2 = dec_mw || (!imm_bit && (mode == 2'b00));

  assign stall = (use_src1 && busy(pend[rn], wb_en && (wb_dest == rn)))
              || (use_src2 && busy(pend[rm], wb_en && (wb_dest == rm)))
              || (dec_wb && (pend[rd] == PEND_MAX))
              || ((cond != 4'b1110) && busy(fpend, sr_update))
              || (dec_s && (fpend == PEND_MAX));

  assign if_ready = rst && !flush && !stall && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;
  assign issue    = accept && cond_ok;
  // EXE owns the slot if it takes it on the flush edge
  assign squash   = flush && ex_valid && !ex_ready;

  always_comb begin
    logic [CW:0] up, down;
    underflow = 1'b0;
    pend_nxt  = '{default: '0};
    for (int unsigned r = 0; r < 16; r++) begin
      up   = cnt_up(pend[r], issue && dec_wb && (rd == r[3:0]));
      down = cnt_down(wb_en && (wb_dest == r[3:0]),
                      squash && ex_wb_en && (ex_dest == r[3:0]));
      pend_nxt[r] = cnt_next(up, down);
      underflow   = underflow || (up < down);
    end
    up        = cnt_up(fpend, issue && dec_s);
    down      = cnt_down(sr_update, squash && ex_s);
    fpend_nxt = cnt_next(up, down);
    underflow = underflow || (up < down);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < 16; r++) pend[r] <= '0;
      fpend <= '0;
    end else begin
      assert (!underflow) else $error("scoreboard counter decremented below zero");
      pend  <= pend_nxt;
      fpend <= fpend_nxt;
    end
  end

  // ID/EXE slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid         <= 1'b0;
      ex_wb_en         <= 1'b0;
      ex_mem_r_en      <= 1'b0;
      ex_mem_w_en      <= 1'b0;
      ex_b             <= 1'b0;
      ex_s             <= 1'b0;
      ex_imm           <= 1'b0;
      ex_exe_cmd       <= '0;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_shift_operand <= '0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_pc            <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (issue) begin
      ex_valid         <= 1'b1;
      ex_wb_en         <= dec_wb;
      ex_mem_r_en      <= dec_mr;
      ex_mem_w_en      <= dec_mw;
      ex_b             <= dec_b;
      ex_s             <= dec_s;
      ex_imm           <= imm_bit;
      ex_exe_cmd       <= dec_cmd;
      ex_val_rn        <= val_rn;
      ex_val_rm        <= val_rm;
      ex_shift_operand <= if_instr[11:0];
      ex_signed_imm_24 <= if_instr[23:0];
      ex_dest          <= rd;
      ex_pc            <= if_pc;
    end else if (ex_ready) begin
      // Drain, or a condition-false accept that leaves the slot empty
      ex_valid <= 1'b0;
    end
  end

endmodule
